// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: read-owner encoding and
// starvation counter width.
package dmem_arb_pkg;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;
endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive arbitration losses of the external port.
// Clear has priority over increment; sat flags the count sitting at MAX.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_W-1:0] cnt;

  assign sat = (cnt == STARVE_W'(MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store port and the
// external loader port; core has priority, external is protected from starvation.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rd_data,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  logic core_req;
  logic core_is_rd;
  logic ext_granted;
  logic core_granted;
  logic starve_inc;
  logic starve_sat;

  owner_e owner;
  owner_e owner_next;

  logic [DATA_W-1:0] core_data_reg;
  logic [DATA_W-1:0] ext_data_reg;

  // A simultaneous write wins over a read on the core port.
  assign core_req     = core_rd | core_wr;
  assign core_is_rd   = core_rd & ~core_wr;
  assign ext_granted  = ext_req & (~core_req | starve_sat);
  assign core_granted = core_req & ~ext_granted;
  assign starve_inc   = ext_req & ~ext_granted;

  assign core_stall = core_req & ~core_granted;
  assign ext_gnt    = ext_granted;

  arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (starve_inc),
    .clr  (~starve_inc),
    .sat  (starve_sat)
  );

  always_comb begin
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (core_granted) begin
      mem_rd      = core_is_rd;
      mem_wr      = core_wr;
      mem_addr    = core_addr;
      mem_wr_data = core_wr_data;
    end else if (ext_granted) begin
      mem_rd      = ~ext_we;
      mem_wr      = ext_we;
      mem_addr    = ext_addr;
      mem_wr_data = ext_wdata;
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (core_granted && core_is_rd) begin
      owner_next = OWN_CORE;
    end else if (ext_granted && !ext_we) begin
      owner_next = OWN_EXT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner         <= OWN_NONE;
      core_data_reg <= '0;
      ext_data_reg  <= '0;
    end else begin
      owner <= owner_next;
      if (owner == OWN_CORE) core_data_reg <= mem_rd_data;
      if (owner == OWN_EXT)  ext_data_reg  <= mem_rd_data;
    end
  end

  // Returned data bypasses the holding register in the return cycle.
  assign core_rvalid  = (owner == OWN_CORE);
  assign ext_rvalid   = (owner == OWN_EXT);
  assign core_rd_data = core_rvalid ? mem_rd_data : core_data_reg;
  assign ext_rdata    = ext_rvalid ? mem_rd_data : ext_data_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: owns the data memory, predicts every cycle from a
// loss-count / pending-read-queue model, plus directed corner sequences.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_rd = 1'b0, core_wr = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wr_data = '0;
  logic          core_stall, core_rvalid;
  logic [DW-1:0] core_rd_data;
  logic          ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wr_data(core_wr_data),
    .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rd_data(core_rd_data),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Environment memory, driven only by the DUT's mem_* outputs.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wr) env_mem[mem_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= env_mem[mem_addr];
  end

  // Reference model state.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            lose_cnt = 0;
  int            pend_owner = 0;   // 0 none, 1 core, 2 ext
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] core_hold = '0, ext_hold = '0;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic          stall, gnt, mrd, mwr, crv, erv;
    logic [DW-1:0] cdata, edata, mwd;
  } obs_t;

  typedef struct {
    logic crd, cwr, ereq, ewe;
    logic exp_stall, exp_gnt, exp_mrd, exp_mwr;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic crd, input logic cwr, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input logic ereq, input logic ewe,
                      input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd,
                      input bit quiet, output obs_t o);
    bit creq, eg, cg, xrd, xwr;
    logic [AW-1:0] xaddr;
    core_rd = crd; core_wr = cwr; core_addr = caddr; core_wr_data = cwd;
    ext_req = ereq; ext_we = ewe; ext_addr = eaddr; ext_wdata = ewd;
    @(negedge clk);
    creq  = crd || cwr;
    eg    = ereq && (!creq || lose_cnt == STARVE_MAX);
    cg    = creq && !eg;
    xrd   = cg ? (crd && !cwr) : (eg ? !ewe : 1'b0);
    xwr   = cg ? cwr : (eg ? ewe : 1'b0);
    xaddr = cg ? caddr : (eg ? eaddr : '0);
    o.stall = core_stall; o.gnt = ext_gnt; o.mrd = mem_rd; o.mwr = mem_wr;
    o.crv = core_rvalid; o.erv = ext_rvalid; o.cdata = core_rd_data;
    o.edata = ext_rdata; o.mwd = mem_wr_data;
    chk("core_stall", {31'b0, core_stall}, {31'b0, creq && !cg});
    chk("ext_gnt", {31'b0, ext_gnt}, {31'b0, eg});
    chk("mem_rd", {31'b0, mem_rd}, {31'b0, xrd});
    chk("mem_wr", {31'b0, mem_wr}, {31'b0, xwr});
    chk("mem_addr", {23'b0, mem_addr}, {23'b0, xaddr});
    if (xwr) chk("mem_wr_data", mem_wr_data, cg ? cwd : ewd);
    if (!cg && !eg) chk("mem_wr_data_idle", mem_wr_data, '0);
    chk("core_rvalid", {31'b0, core_rvalid}, {31'b0, pend_owner == 1});
    chk("ext_rvalid", {31'b0, ext_rvalid}, {31'b0, pend_owner == 2});
    chk("core_rd_data", core_rd_data, (pend_owner == 1) ? pend_data : core_hold);
    chk("ext_rdata", ext_rdata, (pend_owner == 2) ? pend_data : ext_hold);
    if (!quiet)
      $display("[TB] t=%0t core rd=%b wr=%b a=%h | ext req=%b we=%b a=%h | gnt=%b stall=%b crv=%b cd=%h erv=%b ed=%h",
               $time, crd, cwr, caddr, ereq, ewe, eaddr, ext_gnt, core_stall,
               core_rvalid, core_rd_data, ext_rvalid, ext_rdata);
    if (pend_owner == 1) core_hold = pend_data;
    if (pend_owner == 2) ext_hold = pend_data;
    pend_owner = 0;
    if (xrd) begin
      pend_owner = cg ? 1 : 2;
      pend_data  = shadow[xaddr];
    end
    if (xwr) shadow[xaddr] = cg ? cwd : ewd;
    if (ereq && !eg) lose_cnt = (lose_cnt < STARVE_MAX) ? lose_cnt + 1 : STARVE_MAX;
    else lose_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit quiet, output obs_t o);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, quiet, o);
  endtask

  initial begin
    obs_t o;
    vec_t vecs[8];
    logic [DW-1:0] v;
    bit e_pend;
    logic e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_rvalid", {31'b0, core_rvalid}, 32'd0);
    chk("rst_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
    chk("rst_core_rd_data", core_rd_data, 32'd0);
    chk("rst_ext_rdata", ext_rdata, 32'd0);
    chk("rst_mem_strobes", {30'b0, mem_rd, mem_wr}, 32'd0);
    chk("rst_stall_gnt", {30'b0, core_stall, ext_gnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Preload every word through the external write path.
    for (int a = 0; a < (1 << AW); a++) begin
      v = (a == 'h010) ? 32'hDEADBEEF : $urandom;
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(a), v, 1'b1, o);
    end
    idle(1'b1, o);

    // Single-cycle vectors from a quiet state.
    vecs[0] = '{1, 0, 0, 0, 0, 0, 1, 0};
    vecs[1] = '{0, 1, 0, 0, 0, 0, 0, 1};
    vecs[2] = '{1, 1, 0, 0, 0, 0, 0, 1};
    vecs[3] = '{0, 0, 1, 0, 0, 1, 1, 0};
    vecs[4] = '{0, 0, 1, 1, 0, 1, 0, 1};
    vecs[5] = '{1, 0, 1, 0, 0, 0, 1, 0};
    vecs[6] = '{0, 1, 1, 1, 0, 0, 0, 1};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].crd, vecs[i].cwr, 9'h020, 32'hC0DE0000 + i,
           vecs[i].ereq, vecs[i].ewe, 9'h030, 32'hE0000000 + i, 1'b0, o);
      chk($sformatf("vec%0d_stall", i), {31'b0, o.stall}, {31'b0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_gnt", i), {31'b0, o.gnt}, {31'b0, vecs[i].exp_gnt});
      chk($sformatf("vec%0d_mrd", i), {31'b0, o.mrd}, {31'b0, vecs[i].exp_mrd});
      chk($sformatf("vec%0d_mwr", i), {31'b0, o.mwr}, {31'b0, vecs[i].exp_mwr});
      if (vecs[i].ereq && !vecs[i].exp_gnt)
        step(1'b0, 1'b0, '0, '0, 1'b1, vecs[i].ewe, 9'h030, 32'hE0000000 + i, 1'b0, o);
      idle(1'b0, o);
    end

    // Core-only read of 0x010.
    step(1'b1, 1'b0, 9'h010, '0, 1'b0, 1'b0, '0, '0, 1'b0, o);
    chk("cread_mem_rd", {31'b0, o.mrd}, 32'd1);
    chk("cread_stall", {31'b0, o.stall}, 32'd0);
    idle(1'b0, o);
    chk("cread_rvalid", {31'b0, o.crv}, 32'd1);
    chk("cread_data", o.cdata, 32'hDEADBEEF);

    // External write to 0x1FF while core idle.
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 9'h1FF, 32'h12345678, 1'b0, o);
    chk("ewr_gnt", {31'b0, o.gnt}, 32'd1);
    chk("ewr_mem_wr", {31'b0, o.mwr}, 32'd1);
    chk("ewr_wdata", o.mwd, 32'h12345678);
    idle(1'b0, o);
    chk("ewr_no_rvalid", {30'b0, o.crv, o.erv}, 32'd0);

    // Continuous contention: ext wins every STARVE_MAX+1 cycles.
    for (int i = 0; i < 3 * (STARVE_MAX + 1); i++) begin
      step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, 9'h1FF, '0, 1'b0, o);
      chk($sformatf("starve_gnt%0d", i), {31'b0, o.gnt}, {31'b0, (i % (STARVE_MAX + 1)) == STARVE_MAX});
    end
    idle(1'b0, o);

    // Core write with read: write only, no read response.
    step(1'b1, 1'b1, 9'h040, 32'hA5A5A5A5, 1'b0, 1'b0, '0, '0, 1'b0, o);
    chk("wr_rd_strobes", {30'b0, o.mrd, o.mwr}, 32'd1);
    idle(1'b0, o);
    chk("wr_rd_no_rvalid", {31'b0, o.crv}, 32'd0);

    // Back-to-back core read then ext read.
    step(1'b1, 1'b0, 9'h010, '0, 1'b0, 1'b0, '0, '0, 1'b0, o);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h1FF, '0, 1'b0, o);
    chk("b2b_core_rvalid", {30'b0, o.crv, o.erv}, 32'd2);
    idle(1'b0, o);
    chk("b2b_ext_rvalid", {30'b0, o.crv, o.erv}, 32'd1);
    chk("b2b_ext_data", o.edata, 32'h12345678);
    chk("b2b_core_hold", o.cdata, 32'hDEADBEEF);

    // Reset the cycle after an ext read grant.
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h1FF, '0, 1'b0, o);
    reset = 1'b0;
    #1;
    chk("rstmid_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
    chk("rstmid_ext_rdata", ext_rdata, 32'd0);
    chk("rstmid_core_rd_data", core_rd_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    pend_owner = 0; core_hold = '0; ext_hold = '0; lose_cnt = 0;
    for (int i = 0; i < STARVE_MAX + 1; i++) begin
      step(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h1FF, '0, 1'b0, o);
      if (i == 0) chk("rstmid_no_rvalid", {31'b0, o.erv}, 32'd0);
      chk($sformatf("rstmid_gnt%0d", i), {31'b0, o.gnt}, {31'b0, i == STARVE_MAX});
    end
    idle(1'b0, o);

    // Randomized traffic honoring the external hold-until-grant rule.
    e_pend = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      logic crd, cwr;
      int r;
      r = $urandom_range(0, 3);
      crd = (r == 1) || (r == 3);
      cwr = (r == 2) || (r == 3 && $urandom_range(0, 1) == 1);
      if (!e_pend && $urandom_range(0, 2) != 0) begin
        e_pend = 1'b1;
        e_we   = $urandom_range(0, 1) == 1;
        e_addr = AW'($urandom_range(0, 31));
        e_wd   = $urandom;
      end
      step(crd, cwr, AW'($urandom_range(0, 31)), $urandom, e_pend, e_we, e_addr, e_wd, 1'b1, o);
      if (e_pend && (lose_cnt == 0)) e_pend = 1'b0;
    end
    idle(1'b1, o);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory (9-bit word address, 32-bit data) between the core datapath's load/store port and an external loader/debug port. Sits between the `riscv` top's memory-side signals (`wr`, `rd`, `addr`, `wr_data`, `rd_data`) and the data memory. Core has priority, and a starvation counter guarantees the external port forward progress. Tracks the owner of each outstanding one-cycle-latency read and routes the returned data back to that owner only.

## Interface
- `DATA_W`, 32, data width
- `ADDR_W`, 9, word address width
- `STARVE_MAX`, 4, consecutive lost arbitrations after which the external port wins (1..15)

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `core_rd`, `core_wr`  in  1  core read/write request (both high: write wins, read ignored)
- `core_addr`  in  ADDR_W  core address
- `core_wr_data`  in  DATA_W  core store data
- `core_stall`  out  1  core request present but not granted this cycle
- `core_rvalid`  out  1  core read data valid
- `core_rd_data`  out  DATA_W  core read data, held until next core read returns
- `ext_req`, `ext_we`  in  1  external request; write when `ext_we`=1
- `ext_addr`  in  ADDR_W  external address
- `ext_wdata`  in  DATA_W  external write data
- `ext_gnt`  out  1  external request accepted this cycle
- `ext_rvalid`  out  1  external read data valid
- `ext_rdata`  out  DATA_W  external read data, held until next external read returns
- `mem_rd`, `mem_wr`  out  1  memory strobes, never both high
- `mem_addr`  out  ADDR_W  memory address
- `mem_wr_data`  out  DATA_W  memory write data
- `mem_rd_data`  in  DATA_W  memory read data, valid the cycle after `mem_rd`

## Operation
- Arbitration is combinational each cycle. `core_req` = `core_rd`|`core_wr`.
- Only one requester active: it is granted.
- Both active: core granted unless `starve_cnt` == `STARVE_MAX`, in which case ext is granted.
- `starve_cnt` (4 bits):
  - cleared when ext is granted or `ext_req`=0;
  - +1 when `ext_req`=1 and ext is not granted;
  - saturates at `STARVE_MAX`.
- Granted requester's address, data and strobe are muxed onto the `mem_*` outputs. With no grant, all `mem_*` outputs are 0.
- `core_stall` = `core_req` & ~core_granted. `ext_gnt` = ext_granted.
- External handshake: ext holds `ext_req`, `ext_we`, `ext_addr` and `ext_wdata` stable until the cycle `ext_gnt`=1. The transfer occurs in that cycle. Ext may drop or change its request the next cycle.
- Pending-read FSM (`owner` register), states OWN_NONE, OWN_CORE, OWN_EXT:
  - next `owner` = OWN_CORE if core read granted; OWN_EXT if ext read granted; else OWN_NONE;
  - every state can transition to every state each cycle (back-to-back reads supported).
- Read return, in the cycle `owner`≠OWN_NONE:
  - the owner's rvalid = 1;
  - the owner's data register captures `mem_rd_data` at the end of that cycle;
  - the rd_data output is combinational `mem_rd_data` while rvalid=1, else the held register;
  - the other requester's rvalid = 0 and its data register is unchanged.
- Writes produce no response.

## Timing
- Grant/stall: 0-cycle (same cycle as request). Read latency: 1 cycle after grant.
- Reset values: `owner`=OWN_NONE, `starve_cnt`=0, both data registers=0, `core_rvalid`=`ext_rvalid`=0. The `mem_*`, `core_stall` and `ext_gnt` outputs follow the inputs combinationally: 0 when no request.
- Reset asserted mid-read: pending read discarded. No rvalid after reset release for a read granted before reset.
- Simultaneous core read and ext read with `starve_cnt`=`STARVE_MAX`: ext granted, `core_stall`=1, counter clears next edge.
- `STARVE_MAX` boundary: with both requesting continuously, ext wins exactly once every `STARVE_MAX`+1 cycles.
- Reads return in grant order. A return and a new grant can occur in the same cycle.

## Structure
- Package `dmem_arb_pkg`: `owner_e` enum (OWN_NONE, OWN_CORE, OWN_EXT), `STARVE_W`=4 localparam.
- Sub-module `arb_starve_ctr`: saturating counter, inputs `inc`/`clr`, output `sat`, parameter `MAX`. The arbiter instantiates it once.

## Test plan
- Core-only read of addr 0x010 (mem holds 0xDEADBEEF) -> `mem_rd`=1 with addr 0x010, no stall; next cycle `core_rvalid`=1, `core_rd_data`=0xDEADBEEF.
- Ext write 0x1FF←0x12345678 while core idle -> `ext_gnt`=1 same cycle, `mem_wr`=1, `mem_wr_data`=0x12345678; no rvalid on either port.
- Core and ext both requesting reads continuously, `STARVE_MAX`=4 -> core granted 4 cycles, ext granted 5th cycle with `core_stall`=1; pattern repeats; each rvalid lands on the correct port.
- Core write and core read both high -> only `mem_wr` asserted, no `core_rvalid` next cycle.
- Alternating grants, core read then ext read back-to-back -> `core_rvalid` in cycle 2, `ext_rvalid` in cycle 3; `core_rd_data` holds its value through cycle 3.
- `reset` pulled low the cycle after an ext read grant -> `ext_rvalid` stays 0, `ext_rdata`=0, `starve_cnt`=0 after release.
